id_ex_stage: RTL
================

# id_ex_stage

Decode/operand stage directly upstream of the 32-bit ALU. It decodes the instruction's opcode and funct fields into the ALU's 3-bit ALUControl, selects and forwards operands, and registers everything into the ID/EX pipeline register that drives the ALU's A, B and ALUControl inputs. Stall and flush controls let the hazard logic hold or bubble the stage.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold all output registers
- flush  in  1  load a bubble
- in_valid  in  1  decode-stage instruction present
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- rs, rt, rd  in  5 each  register indices
- imm16  in  16  instr[15:0]
- rs_data, rt_data  in  32 each  register-file read data
- exmem_regwrite, memwb_regwrite  in  1 each  later-stage write enables
- exmem_rd, memwb_rd  in  5 each  later-stage destinations
- exmem_result, memwb_result  in  32 each  later-stage results
- A, B  out  32 each  registered ALU operands
- ALUControl  out  3  registered ALU op
- dest_reg  out  5  registered write-back index
- reg_write  out  1  registered write enable
- valid  out  1  registered slot-valid
- illegal  out  1  registered unsupported-encoding flag

## Operation
- Decode: opcode 0x00 with funct 0x20 gives ADD 000; funct 0x22 gives SUB 001; funct 0x26 gives XOR 010. For R-type, B = forwarded rt and dest = rd.
- opcode 0x08 (addi) gives 000, B = sign-extended imm16, dest = rt.
- opcode 0x0E (xori) gives 010, B = zero-extended imm16, dest = rt.
- Any other encoding with in_valid=1: ALUControl=111 (the ALU outputs 0), reg_write=0, illegal=1, valid=1, A=B=0.
- Forwarding, applied to rs for A and to rt for R-type B:
  - When the index is 0, use the register-file data unchanged. No forwarding to $0.
  - When exmem_regwrite is high and exmem_rd equals the index, use exmem_result.
  - Else when memwb_regwrite is high and memwb_rd equals the index, use memwb_result.
  - Else use rs_data or rt_data.
  - EX/MEM always wins when both stages match.
- reg_write = in_valid & legal & (dest != 0).
- Bubble: valid=0, reg_write=0, illegal=0, ALUControl=111, A=B=0, dest_reg=0.
- Register update priority each posedge: reset, then flush, then stall, then normal load.
  - Normal load with in_valid=0 loads a bubble.
  - flush with stall both high loads a bubble.
  - While stalled, all outputs hold bit-exact. Operands are not re-forwarded.
- Arithmetic: imm sign extension is {{16{imm16[15]}}, imm16}; zero extension is {16'b0, imm16}. No arithmetic in this block.

## Timing
- Reset: every output 0 except ALUControl=111 (bubble state), effective at the first posedge with reset high.
- Latency: decode inputs at cycle N appear on outputs after posedge N+1. The ALU registers R at posedge N+2.
- Forwarding muxes are combinational on same-cycle inputs ahead of the register.
- stall is level-sensitive. Each stalled cycle holds one more cycle, and release loads the current inputs on the next posedge.
- flush lasts one cycle; outputs return to normal loading the following edge.
- Reset mid-stall or mid-flush: reset wins and produces the bubble state.

## Test plan
- Reset: hold reset 2 cycles with arbitrary inputs. Then valid=0, A=B=0, ALUControl=111, reg_write=0, illegal=0.
- R-type decode: opcode 0, funct 0x22, rs=1 (data 10), rt=2 (data 3), rd=4, no forwarding. Next cycle A=10, B=3, ALUControl=001, dest_reg=4, reg_write=1. One cycle later the ALU shows R=7.
- Immediates: addi with imm16=0xFFFF gives B=0xFFFFFFFF and ALUControl=000. xori with imm16=0x8001 gives B=0x00008001 and ALUControl=010. dest_reg=rt in both cases.
- Forwarding priority: rs=5; exmem (rd=5, data 0xAAAA) and memwb (rd=5, data 0xBBBB) both writing, so A=0xAAAA. With exmem_regwrite=0, A=0xBBBB. With rs=0 and both stages matching index 0, A=rs_data.
- Stall and flush: load an ADD, then assert stall 3 cycles while changing inputs; outputs stay unchanged. Assert flush with stall both high; the next edge is a bubble (valid=0).
- Illegal and $0 destination: opcode 0x23 gives illegal=1, ALUControl=111, reg_write=0. addi with rt=0 gives reg_write=0, illegal=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle between the decode side and the ID/EX register: decode fields, forwarding
// sources and hazard controls in; registered ALU operands and control out.
interface id_ex_stage_if;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        exmem_regwrite;
   logic        memwb_regwrite;
   logic [4:0]  exmem_rd;
   logic [4:0]  memwb_rd;
   logic [31:0] exmem_result;
   logic [31:0] memwb_result;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUControl;
   logic [4:0]  dest_reg;
   logic        reg_write;
   logic        valid;
   logic        illegal;

   modport master (
      output stall, flush, in_valid, opcode, funct, rs, rt, rd, imm16,
             rs_data, rt_data, exmem_regwrite, memwb_regwrite, exmem_rd,
             memwb_rd, exmem_result, memwb_result,
      input  A, B, ALUControl, dest_reg, reg_write, valid, illegal
   );

   modport slave (
      input  stall, flush, in_valid, opcode, funct, rs, rt, rd, imm16,
             rs_data, rt_data, exmem_regwrite, memwb_regwrite, exmem_rd,
             memwb_rd, exmem_result, memwb_result,
      output A, B, ALUControl, dest_reg, reg_write, valid, illegal
   );
endinterface

// File: rtl/id_ex_stage.sv
// Decode/operand stage feeding the 32-bit ALU: decodes opcode/funct into ALUControl,
// forwards operands from EX/MEM and MEM/WB, and registers the result into ID/EX.
module id_ex_stage (
   input logic         clk,
   input logic         reset,
   id_ex_stage_if.slave bus
);

   logic [31:0] fwdA;
   logic [31:0] fwdB;
   logic [31:0] nextA;
   logic [31:0] nextB;
   logic [2:0]  nextAlu;
   logic [4:0]  nextDest;
   logic        nextLegal;

   // EX/MEM is the younger result so it takes precedence; $0 is never forwarded.
   always_comb begin
      fwdA = bus.rs_data;
      if (bus.rs != 5'd0) begin
         if (bus.exmem_regwrite && (bus.exmem_rd == bus.rs))
            fwdA = bus.exmem_result;
         else if (bus.memwb_regwrite && (bus.memwb_rd == bus.rs))
            fwdA = bus.memwb_result;
      end
   end

   always_comb begin
      fwdB = bus.rt_data;
      if (bus.rt != 5'd0) begin
         if (bus.exmem_regwrite && (bus.exmem_rd == bus.rt))
            fwdB = bus.exmem_result;
         else if (bus.memwb_regwrite && (bus.memwb_rd == bus.rt))
            fwdB = bus.memwb_result;
      end
   end

   always_comb begin
      nextLegal = 1'b1;
      nextAlu   = 3'b111;
      nextA     = fwdA;
      nextB     = 32'd0;
      nextDest  = 5'd0;
      case (bus.opcode)
         6'h00: begin
            nextB    = fwdB;
            nextDest = bus.rd;
            case (bus.funct)
               6'h20:   nextAlu = 3'b000;
               6'h22:   nextAlu = 3'b001;
               6'h26:   nextAlu = 3'b010;
               default: nextLegal = 1'b0;
            endcase
         end
         6'h08: begin
            nextAlu  = 3'b000;
            nextB    = {{16{bus.imm16[15]}}, bus.imm16};
            nextDest = bus.rt;
         end
         6'h0E: begin
            nextAlu  = 3'b010;
            nextB    = {16'b0, bus.imm16};
            nextDest = bus.rt;
         end
         default: nextLegal = 1'b0;
      endcase
      // Illegal slots stay valid but carry zero operands, op 111 and no destination.
      if (!nextLegal) begin
         nextA    = 32'd0;
         nextB    = 32'd0;
         nextAlu  = 3'b111;
         nextDest = 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.flush || (!bus.stall && !bus.in_valid)) begin
         bus.A          <= 32'd0;
         bus.B          <= 32'd0;
         bus.ALUControl <= 3'b111;
         bus.dest_reg   <= 5'd0;
         bus.reg_write  <= 1'b0;
         bus.valid      <= 1'b0;
         bus.illegal    <= 1'b0;
      end else if (!bus.stall) begin
         bus.A          <= nextA;
         bus.B          <= nextB;
         bus.ALUControl <= nextAlu;
         bus.dest_reg   <= nextDest;
         bus.reg_write  <= nextLegal && (nextDest != 5'd0);
         bus.valid      <= 1'b1;
         bus.illegal    <= !nextLegal;
      end
   end

endmodule
